sad_search_scheduler: RTL
=========================

// Module: sad_search_scheduler
// PURPOSE
//   Sequences the SAD custom-instruction datapath over a full frame search.
//   Issues window coordinates in raster order into the EX pipeline and tracks
//   in-flight windows against a credit limit. Consumes SAD results returning
//   from EX6 and keeps the running minimum, then reports Best_X/Best_Y/Best_Sad
//   (feeding outx/outy/sad). Sits beside the decode/EX1 stage; one search per Start.
// PARAMETERS
//   FRAME_W   64  frame width in pixels (>= WIN)
//   FRAME_H   64  frame height in pixels (>= WIN)
//   WIN        4  square window edge (4 -> 16 ReadData/tReadData words)
//   PIPE_LAT   6  max in-flight windows (EX1..EX6 depth); credit limit, >= 1
//   CW         8  coordinate width; must hold FRAME_W-WIN and FRAME_H-WIN
// PORTS
//   Clk          in   1   clock, rising edge
//   Reset        in   1   synchronous, active-high
//   Start        in   1   begin search; sampled only in IDLE
//   Stall        in   1   datapath stall; no issue in a cycle with Stall=1
//   Issue_Valid  out  1   window issued this cycle
//   Issue_X      out  CW  issued window column (top-left)
//   Issue_Y      out  CW  issued window row (top-left)
//   Sad_Valid    in   1   SAD result valid from EX6, in issue order
//   Sad_Value    in   32  unsigned SAD of oldest in-flight window
//   Busy         out  1   high in ISSUE and DRAIN
//   Done         out  1   one-cycle pulse when result final
//   Best_X       out  32  column of minimum SAD, zero-extended
//   Best_Y       out  32  row of minimum SAD, zero-extended
//   Best_Sad     out  32  minimum SAD found
// BEHAVIOUR
//   Reset: state=IDLE; Issue_Valid=0, Issue_X=Issue_Y=0, Busy=0, Done=0,
//     Best_X=Best_Y=0, Best_Sad=32'hFFFF_FFFF; issue/return counters, credit=0.
//   FSM: IDLE -Start-> ISSUE -last window issued-> DRAIN -credit==0-> DONE -> IDLE.
//   On Start (IDLE): zero counters, Best_Sad=FFFF_FFFF, Best_X/Y=0; next cycle ISSUE.
//   ISSUE: Issue_Valid=1 iff !Stall && credit<PIPE_LAT; registered output, 1 cycle
//     after decision. Order: X 0..FRAME_W-WIN fastest, then Y 0..FRAME_H-WIN.
//   Total windows N=(FRAME_W-WIN+1)*(FRAME_H-WIN+1); ISSUE->DRAIN after N-th issue.
//   Credit: +1 per issue, -1 per Sad_Valid; same cycle -> unchanged. Never >PIPE_LAT.
//   Return coordinate counter (RX,RY) advances in same raster order per Sad_Valid.
//   Update: Sad_Value < Best_Sad (strict, unsigned) -> Best_*<=Sad_Value,RX,RY next
//     cycle. Ties keep earliest window.
//   DRAIN->DONE when credit==0 after final return; DONE lasts 1 cycle (Done=1,
//     Busy=0); Best_* hold until next Start.
//   Sad_Valid in IDLE/DONE or with credit==0: ignored, no state change.
//   Start while Busy: ignored. Start in DONE: ignored (take effect from IDLE).
//   Reset mid-search: immediate abort to reset values; datapath shares Reset so no
//     stale results return.
//   N==1 (FRAME=WIN): one issue, ISSUE->DRAIN directly.
// CONFIGURATION
//   SAD_SEARCH_EARLY_EXIT_EN defined: a returned Sad_Value==0 stops further issue
//     (ISSUE->DRAIN next cycle); in-flight results still consumed but cannot replace
//     the zero; Done after credit reaches 0.
//   Not defined: full N-window scan always, regardless of SAD values.
// TESTING
//   FRAME 8x8, WIN 4, Stall=0, SAD=100-index -> 25 issues, Best=(4,4,76), Done once.
//   Same, pipe latency 10 > PIPE_LAT=6 -> issue pauses at credit 6, never exceeds.
//   Stall high cycles 3-7 -> no Issue_Valid during them; order and count unchanged.
//   Equal SAD=5 at (1,0) and (3,2), rest 9 -> Best=(1,0,5) (tie keeps first).
//   Reset pulsed at window 12 -> all outputs reset next cycle; new Start rescans 25.
//   EARLY_EXIT_EN, SAD=0 at window 7 -> issue stops, Best=(2,1,0), Done after drain.

Source files
------------

// File: rtl/sad_search_scheduler.sv
// Raster-order window issuer with credit-limited in-flight tracking and running-minimum SAD capture.
// Optional macro SAD_SEARCH_EARLY_EXIT_EN: a returned SAD of zero ends issuing early.
module sad_search_scheduler #(
  parameter int FRAME_W  = 64,
  parameter int FRAME_H  = 64,
  parameter int WIN      = 4,
  parameter int PIPE_LAT = 6,
  parameter int CW       = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_stall,
  output logic          o_issueValid,
  output logic [CW-1:0] o_issueX,
  output logic [CW-1:0] o_issueY,
  input  logic          i_sadValid,
  input  logic [31:0]   i_sadValue,
  output logic          o_busy,
  output logic          o_done,
  output logic [31:0]   o_bestX,
  output logic [31:0]   o_bestY,
  output logic [31:0]   o_bestSad
);

  localparam int XMAX = FRAME_W - WIN;
  localparam int YMAX = FRAME_H - WIN;
  localparam int CRW  = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [CW-1:0]  r_issX;
  logic [CW-1:0]  r_issY;
  logic [CW-1:0]  r_retX;
  logic [CW-1:0]  r_retY;
  logic [CW-1:0]  r_bestX;
  logic [CW-1:0]  r_bestY;
  logic [31:0]    r_bestSad;
  logic [CRW-1:0] r_credit;
  logic           r_issueValid;
  logic [CW-1:0]  r_issueX;
  logic [CW-1:0]  r_issueY;
  logic           w_issue;
  logic           w_lastIssue;
  logic           w_accept;
  logic           w_zeroHit;

  assign w_issue     = (r_state == ISSUE) && !i_stall && (r_credit < CRW'(PIPE_LAT));
  assign w_lastIssue = (r_issX == CW'(XMAX)) && (r_issY == CW'(YMAX));
  // Returns are only meaningful while something is actually in flight.
  assign w_accept    = i_sadValid && ((r_state == ISSUE) || (r_state == DRAIN)) &&
                       (r_credit != '0);

`ifdef SAD_SEARCH_EARLY_EXIT_EN
  assign w_zeroHit = w_accept && (i_sadValue == 32'd0);
`else
  assign w_zeroHit = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = ISSUE;
      ISSUE:   if ((w_issue && w_lastIssue) || w_zeroHit) w_nextState = DRAIN;
      DRAIN:   if (r_credit == '0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_issX       <= '0;
      r_issY       <= '0;
      r_retX       <= '0;
      r_retY       <= '0;
      r_bestX      <= '0;
      r_bestY      <= '0;
      r_bestSad    <= 32'hFFFF_FFFF;
      r_credit     <= '0;
      r_issueValid <= 1'b0;
      r_issueX     <= '0;
      r_issueY     <= '0;
    end else begin
      r_state      <= w_nextState;
      r_issueValid <= w_issue;

      if (r_state == IDLE && i_start) begin
        r_issX    <= '0;
        r_issY    <= '0;
        r_retX    <= '0;
        r_retY    <= '0;
        r_credit  <= '0;
        r_bestX   <= '0;
        r_bestY   <= '0;
        r_bestSad <= 32'hFFFF_FFFF;
      end else begin
        if (w_issue) begin
          r_issueX <= r_issX;
          r_issueY <= r_issY;
          if (r_issX == CW'(XMAX)) begin
            r_issX <= '0;
            r_issY <= r_issY + 1'b1;
          end else begin
            r_issX <= r_issX + 1'b1;
          end
        end

        if (w_issue && !w_accept) r_credit <= r_credit + 1'b1;
        else if (!w_issue && w_accept) r_credit <= r_credit - 1'b1;

        // Return coordinates mirror issue order; strict compare keeps the earliest tie.
        if (w_accept) begin
          if (r_retX == CW'(XMAX)) begin
            r_retX <= '0;
            r_retY <= r_retY + 1'b1;
          end else begin
            r_retX <= r_retX + 1'b1;
          end
          if (i_sadValue < r_bestSad) begin
            r_bestSad <= i_sadValue;
            r_bestX   <= r_retX;
            r_bestY   <= r_retY;
          end
        end
      end
    end
  end

  assign o_issueValid = r_issueValid;
  assign o_issueX     = r_issueX;
  assign o_issueY     = r_issueY;
  assign o_busy       = (r_state == ISSUE) || (r_state == DRAIN);
  assign o_done       = (r_state == DONE);
  assign o_bestX      = 32'(r_bestX);
  assign o_bestY      = 32'(r_bestY);
  assign o_bestSad    = r_bestSad;

endmodule
